// File: rtl/mux64_arbiter_pkg.sv
// Shared types and constants for the two-requester 64-bit mux arbiter.
package mux64_arbiter_pkg;

  // Ownership state of the shared mux.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  // Requester identifiers, used for Last, Y_Src and Select.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Default datapath width and burst limit (burst limit legal range 1..15).
  localparam int DEF_WIDTH     = 64;
  localparam int DEF_BURST_MAX = 4;

endpackage

// File: rtl/mux_arb_fsm.sv
// Ownership FSM: tracks the current owner, the last released owner and the
// burst count; produces the mux select, per-requester ready and load strobe.
module mux_arb_fsm
  import mux64_arbiter_pkg::*;
#(
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic y_valid,
  input  logic y_ready,
  output logic select,
  output logic a_ready,
  output logic b_ready,
  output logic load
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       slot_free_s;
  logic [3:0] cnt_inc_s;
  logic       burst_done_s;

  // The output slot can accept a word when empty or draining this cycle.
  assign slot_free_s  = !y_valid || y_ready;
  assign cnt_inc_s    = cnt_q + 4'd1;
  assign burst_done_s = (cnt_inc_s == BURST_LIM);

  // Ready and select depend only on registered state and the consumer ready.
  assign a_ready = (state_q == ST_OWN_A) && slot_free_s;
  assign b_ready = (state_q == ST_OWN_B) && slot_free_s;
  assign select  = (state_q == ST_OWN_B);

  // State, last-owner and burst-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= SRC_B;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: grant from idle, burst limiting, release on Valid low.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (a_valid && b_valid) begin
          state_d = (last_q == SRC_B) ? ST_OWN_A : ST_OWN_B;
        end else if (a_valid) begin
          state_d = ST_OWN_A;
        end else if (b_valid) begin
          state_d = ST_OWN_B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_A: begin
        if (!a_valid) begin
          last_d  = SRC_A;
          cnt_d   = 4'd0;
          state_d = b_valid ? ST_OWN_B : ST_IDLE;
        end else if (slot_free_s) begin
          load = 1'b1;
          if (burst_done_s) begin
            cnt_d = 4'd0;
            if (b_valid) begin
              state_d = ST_OWN_B;
              last_d  = SRC_A;
            end else begin
              state_d = ST_OWN_A;
            end
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          // Stalled owner keeps the mux; never pre-empted.
          state_d = ST_OWN_A;
        end
      end
      ST_OWN_B: begin
        if (!b_valid) begin
          last_d  = SRC_B;
          cnt_d   = 4'd0;
          state_d = a_valid ? ST_OWN_A : ST_IDLE;
        end else if (slot_free_s) begin
          load = 1'b1;
          if (burst_done_s) begin
            cnt_d = 4'd0;
            if (a_valid) begin
              state_d = ST_OWN_A;
              last_d  = SRC_B;
            end else begin
              state_d = ST_OWN_B;
            end
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          state_d = ST_OWN_B;
        end
      end
      default: begin
        state_d = ST_IDLE;
        last_d  = SRC_B;
        cnt_d   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/mux64_arbiter.sv
// Round-robin, burst-limited arbiter sharing a 2:1 datapath mux between two
// producers, with a single-entry registered output stage.
module mux64_arbiter
  import mux64_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             A_Valid,
  output logic             A_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic             B_Valid,
  output logic             B_Ready,
  input  logic [WIDTH-1:0] B,
  output logic             Y_Valid,
  input  logic             Y_Ready,
  output logic [WIDTH-1:0] Y,
  output logic             Y_Src,
  output logic             Select
);

  logic             load_s;
  logic [WIDTH-1:0] mux_word_s;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_src_q, y_src_d;
  logic             y_valid_q, y_valid_d;

  mux_arb_fsm #(
    .BURST_MAX(BURST_MAX)
  ) u_fsm (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .a_valid(A_Valid),
    .b_valid(B_Valid),
    .y_valid(y_valid_q),
    .y_ready(Y_Ready),
    .select (Select),
    .a_ready(A_Ready),
    .b_ready(B_Ready),
    .load   (load_s)
  );

  // The shared datapath mux, steered only by the arbiter.
  assign mux_word_s = (Select == SRC_B) ? B : A;

  // Output stage next value: load wins over drain; data holds when idle.
  always_comb begin
    y_d       = y_q;
    y_src_d   = y_src_q;
    y_valid_d = y_valid_q;
    if (load_s) begin
      y_d       = mux_word_s;
      y_src_d   = Select;
      y_valid_d = 1'b1;
    end else if (Y_Ready) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end
  end

  // Output stage registers; reset discards any held word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      y_q       <= {WIDTH{1'b0}};
      y_src_q   <= SRC_A;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_src_q   <= y_src_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign Y       = y_q;
  assign Y_Src   = y_src_q;
  assign Y_Valid = y_valid_q;

endmodule

// File: tb/tb_mux64_arbiter.sv
// Directed testbench for mux64_arbiter with hand-computed expectations.
module tb_mux64_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic        A_Valid, A_Ready;
  logic [63:0] A;
  logic        B_Valid, B_Ready;
  logic [63:0] B;
  logic        Y_Valid, Y_Ready;
  logic [63:0] Y;
  logic        Y_Src;
  logic        Select;

  int vectors;
  int miscompares;

  localparam logic [63:0] A_BASE = 64'hA000_0000_0000_0000;
  localparam logic [63:0] B_BASE = 64'hB000_0000_0000_0000;

  mux64_arbiter dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .A_Valid(A_Valid),
    .A_Ready(A_Ready),
    .A      (A),
    .B_Valid(B_Valid),
    .B_Ready(B_Ready),
    .B      (B),
    .Y_Valid(Y_Valid),
    .Y_Ready(Y_Ready),
    .Y      (Y),
    .Y_Src  (Y_Src),
    .Select (Select)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Apply reset with idle inputs; leaves the bench at "cycle 0".
  task automatic do_reset();
    Rst_n   = 1'b0;
    A_Valid = 1'b0;
    B_Valid = 1'b0;
    A       = 64'h0;
    B       = 64'h0;
    Y_Ready = 1'b1;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    Rst_n = 1'b0;
    #1;
    vectors++; if (Y_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_y_valid got %0b exp 0", Y_Valid); end
    vectors++; if (Y !== 64'h0) begin miscompares++; $display("FAIL reset_y got %h exp 0", Y); end
    vectors++; if (Y_Src !== 1'b0) begin miscompares++; $display("FAIL reset_y_src got %0b exp 0", Y_Src); end
    vectors++; if (Select !== 1'b0) begin miscompares++; $display("FAIL reset_select got %0b exp 0", Select); end
    vectors++; if ({A_Ready, B_Ready} !== 2'b00) begin miscompares++; $display("FAIL reset_readys got %b exp 00", {A_Ready, B_Ready}); end
    do_reset();
    // Neither valid: ready stays low in IDLE.
    tick();
    vectors++; if ({A_Ready, B_Ready} !== 2'b00) begin miscompares++; $display("FAIL idle_readys got %b exp 00", {A_Ready, B_Ready}); end
  endtask

  task automatic test_single_word();
    do_reset();
    A_Valid = 1'b1;
    A       = 64'h1;
    tick(); // cycle 1
    vectors++; if (A_Ready !== 1'b1) begin miscompares++; $display("FAIL single_a_ready got %0b exp 1", A_Ready); end
    vectors++; if (Y_Valid !== 1'b0) begin miscompares++; $display("FAIL single_y_valid_c1 got %0b exp 0", Y_Valid); end
    tick(); // cycle 2
    A_Valid = 1'b0;
    A       = 64'hDEAD;
    vectors++; if (Y !== 64'h1) begin miscompares++; $display("FAIL single_y got %h exp 1", Y); end
    vectors++; if (Y_Src !== 1'b0) begin miscompares++; $display("FAIL single_y_src got %0b exp 0", Y_Src); end
    vectors++; if (Y_Valid !== 1'b1) begin miscompares++; $display("FAIL single_y_valid_c2 got %0b exp 1", Y_Valid); end
    vectors++; if (Select !== 1'b0) begin miscompares++; $display("FAIL single_select got %0b exp 0", Select); end
    tick(); // cycle 3: drained, A released
    vectors++; if (Y_Valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %0b exp 0", Y_Valid); end
    vectors++; if (Y !== 64'h1) begin miscompares++; $display("FAIL single_y_hold got %h exp 1", Y); end
  endtask

  task automatic test_round_robin();
    logic        exp_src;
    logic [63:0] exp_y;
    do_reset();
    A_Valid = 1'b1;
    B_Valid = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      A = A_BASE | 64'(k);
      B = B_BASE | 64'(k);
      tick(); // now cycle k+1
      // Owner during cycle m (m>=1): A for 1..4, B for 5..8, A for 9..12.
      exp_src = 1'(((k + 1 - 1) / 4) % 2);
      vectors++; if (Select !== exp_src) begin miscompares++; $display("FAIL rr_select cyc %0d got %0b exp %0b", k + 1, Select, exp_src); end
      if (k >= 1) begin
        exp_src = 1'(((k - 1) / 4) % 2);
        exp_y   = (exp_src ? B_BASE : A_BASE) | 64'(k);
        vectors++; if (Y_Valid !== 1'b1) begin miscompares++; $display("FAIL rr_y_valid cyc %0d got %0b exp 1", k + 1, Y_Valid); end
        vectors++; if (Y_Src !== exp_src) begin miscompares++; $display("FAIL rr_y_src cyc %0d got %0b exp %0b", k + 1, Y_Src, exp_src); end
        vectors++; if (Y !== exp_y) begin miscompares++; $display("FAIL rr_y cyc %0d got %h exp %h", k + 1, Y, exp_y); end
      end
    end
    A_Valid = 1'b0;
    B_Valid = 1'b0;
  endtask

  task automatic test_b_stream();
    int accepted;
    accepted = 0;
    do_reset();
    B_Valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      B = B_BASE | 64'(k);
      tick(); // cycle k+1
      if (k + 1 == 11) B_Valid = 1'b0;
      vectors++; if ({Select, B_Ready, A_Ready} !== 3'b110) begin miscompares++; $display("FAIL bs_ctrl cyc %0d got %b exp 110", k + 1, {Select, B_Ready, A_Ready}); end
      if (B_Valid && B_Ready) accepted++;
      if (k >= 1) begin
        vectors++; if ({Y_Valid, Y_Src} !== 2'b11) begin miscompares++; $display("FAIL bs_valid_src cyc %0d got %b exp 11", k + 1, {Y_Valid, Y_Src}); end
        vectors++; if (Y !== (B_BASE | 64'(k))) begin miscompares++; $display("FAIL bs_y cyc %0d got %h exp %h", k + 1, Y, B_BASE | 64'(k)); end
      end
    end
    vectors++; if (accepted !== 10) begin miscompares++; $display("FAIL bs_accepted got %0d exp 10", accepted); end
    tick();
    vectors++; if (Y_Valid !== 1'b0) begin miscompares++; $display("FAIL bs_drain got %0b exp 0", Y_Valid); end
  endtask

  task automatic test_stall();
    do_reset();
    A_Valid = 1'b1;
    A       = 64'h0000_0000_0000_00A1;
    tick(); // cycle 1: OWN_A, transfer A1
    tick(); // cycle 2: Y=A1
    A       = 64'h0000_0000_0000_00A2;
    B_Valid = 1'b1;
    B       = 64'h0000_0000_0000_00B1;
    Y_Ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if ({A_Ready, B_Ready} !== 2'b00) begin miscompares++; $display("FAIL stall_readys c %0d got %b exp 00", c, {A_Ready, B_Ready}); end
      vectors++; if (Select !== 1'b0) begin miscompares++; $display("FAIL stall_select c %0d got %0b exp 0", c, Select); end
      vectors++; if ({Y_Valid, Y} !== {1'b1, 64'h0000_0000_0000_00A1}) begin miscompares++; $display("FAIL stall_y c %0d got %0b/%h exp 1/a1", c, Y_Valid, Y); end
      tick();
    end
    Y_Ready = 1'b1;
    #1;
    vectors++; if (A_Ready !== 1'b1) begin miscompares++; $display("FAIL stall_resume_ready got %0b exp 1", A_Ready); end
    tick();
    vectors++; if ({Y_Valid, Y_Src, Y} !== {1'b1, 1'b0, 64'h0000_0000_0000_00A2}) begin miscompares++; $display("FAIL stall_resume_y got %0b/%0b/%h exp 1/0/a2", Y_Valid, Y_Src, Y); end
    vectors++; if (Select !== 1'b0) begin miscompares++; $display("FAIL stall_resume_select got %0b exp 0", Select); end
    A_Valid = 1'b0;
    B_Valid = 1'b0;
  endtask

  task automatic test_release();
    do_reset();
    A_Valid = 1'b1;
    B_Valid = 1'b1;
    A       = 64'h0000_0000_0000_0A01;
    B       = 64'h0000_0000_0000_0B01;
    tick(); // cycle 1: OWN_A, transfer A
    tick(); // cycle 2: A drops valid
    A_Valid = 1'b0;
    tick(); // cycle 3: OWN_B, bubble
    vectors++; if ({Select, B_Ready, A_Ready} !== 3'b110) begin miscompares++; $display("FAIL rel_own_b got %b exp 110", {Select, B_Ready, A_Ready}); end
    vectors++; if (Y_Valid !== 1'b0) begin miscompares++; $display("FAIL rel_bubble got %0b exp 0", Y_Valid); end
    tick(); // cycle 4: B word out; B releases, nobody requests
    vectors++; if ({Y_Valid, Y_Src, Y} !== {1'b1, 1'b1, 64'h0000_0000_0000_0B01}) begin miscompares++; $display("FAIL rel_b_word got %0b/%0b/%h exp 1/1/b01", Y_Valid, Y_Src, Y); end
    B_Valid = 1'b0;
    tick(); // cycle 5: IDLE, Last=B
    A_Valid = 1'b1;
    B_Valid = 1'b1;
    tick(); // cycle 6: tie resolved to A
    vectors++; if ({Select, A_Ready, B_Ready} !== 3'b010) begin miscompares++; $display("FAIL rel_tie got %b exp 010", {Select, A_Ready, B_Ready}); end
    A_Valid = 1'b0;
    B_Valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    A_Valid = 1'b1;
    B_Valid = 1'b1;
    A       = 64'h0000_0000_0000_AAAA;
    B       = 64'h0000_0000_0000_BBBB;
    repeat (6) tick(); // cycle 6: OWN_B mid-burst, Y holds a B word
    vectors++; if ({Select, B_Ready, Y_Valid, Y_Src} !== 4'b1111) begin miscompares++; $display("FAIL rm_pre got %b exp 1111", {Select, B_Ready, Y_Valid, Y_Src}); end
    #2;
    Rst_n = 1'b0;
    #1;
    vectors++; if ({Y_Valid, Select, A_Ready, B_Ready} !== 4'b0000) begin miscompares++; $display("FAIL rm_ctrl got %b exp 0000", {Y_Valid, Select, A_Ready, B_Ready}); end
    vectors++; if (Y !== 64'h0) begin miscompares++; $display("FAIL rm_y got %h exp 0", Y); end
    tick();
    vectors++; if ({A_Ready, B_Ready} !== 2'b00) begin miscompares++; $display("FAIL rm_held got %b exp 00", {A_Ready, B_Ready}); end
    Rst_n = 1'b1;
    tick();
    vectors++; if ({Select, A_Ready, B_Ready} !== 3'b010) begin miscompares++; $display("FAIL rm_tie got %b exp 010", {Select, A_Ready, B_Ready}); end
    A_Valid = 1'b0;
    B_Valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_b_stream();
    test_stall();
    test_release();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
